// File: rtl/bin2seg_seq.sv
// Sequential binary-to-7-segment driver: iterative double-dabble (one bit per cycle), then formatting
// with signed mode, leading-zero blanking, decimal points and overflow dashes.
module bin2seg_seq #(
    parameter int N_DIGITS = 4,
    parameter int W_IN     = 14,
    parameter int SIGNED   = 0
) (
    input  logic                  i_CLK,
    input  logic                  i_RST_n,
    input  logic                  i_start,
    input  logic [W_IN-1:0]       i_value,
    input  logic [N_DIGITS-1:0]   i_DP,
    input  logic                  i_blank_lz,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_ovf,
    output logic [8*N_DIGITS-1:0] o_SEG
);

    localparam int BW = 4 * (N_DIGITS + 1);
    localparam int CW = (W_IN > 1) ? $clog2(W_IN) : 1;

    localparam logic [6:0] GLY_BLANK = 7'b1111111;
    localparam logic [6:0] GLY_DASH  = 7'b0111111;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FORMAT, S_OUT} state_t;

    state_t                  r_state, w_next;
    logic [CW-1:0]           r_cnt;
    logic [W_IN-1:0]         r_mag;
    logic [BW-1:0]           r_bcd;
    logic                    r_lost;
    logic                    r_neg;
    logic [N_DIGITS-1:0]     r_dp;
    logic                    r_blz;
    logic [8*N_DIGITS-1:0]   r_fmt;
    logic                    r_fmt_ovf;
    logic [8*N_DIGITS-1:0]   r_seg;
    logic                    r_ovf;
    logic                    r_done;

    logic                    w_neg_in;
    logic [W_IN-1:0]         w_mag_in;
    logic [BW-1:0]           w_bcd_adj;
    logic [8*N_DIGITS-1:0]   w_fmt;
    logic                    w_ovf;

    function automatic logic [6:0] f_glyph(input logic [3:0] n);
        case (n)
            4'd0:    f_glyph = 7'b1000000;
            4'd1:    f_glyph = 7'b1111001;
            4'd2:    f_glyph = 7'b0100100;
            4'd3:    f_glyph = 7'b0110000;
            4'd4:    f_glyph = 7'b0011001;
            4'd5:    f_glyph = 7'b0010010;
            4'd6:    f_glyph = 7'b0000010;
            4'd7:    f_glyph = 7'b1111000;
            4'd8:    f_glyph = 7'b0000000;
            4'd9:    f_glyph = 7'b0010000;
            default: f_glyph = GLY_BLANK;
        endcase
    endfunction

    // Negating in W_IN bits maps -2^(W_IN-1) onto itself, which reads correctly as an unsigned magnitude.
    assign w_neg_in = (SIGNED != 0) && i_value[W_IN-1];
    assign w_mag_in = w_neg_in ? (~i_value + W_IN'(1)) : i_value;

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int n = 0; n < N_DIGITS + 1; n++) begin
            if (r_bcd[4*n +: 4] >= 4'd5)
                w_bcd_adj[4*n +: 4] = r_bcd[4*n +: 4] + 4'd3;
        end
    end

    // Overflow: guard digit or bits lost off the top, or a negative value filling every digit.
    always_comb begin : fmt
        int         msnz;
        int         hdp;
        int         top;
        int         mpos;
        logic [6:0] g;
        w_ovf = r_lost | (r_bcd[BW-1 -: 4] != 4'd0) |
                (r_neg & (r_bcd[4*(N_DIGITS-1) +: 4] != 4'd0));
        msnz  = 0;
        hdp   = 0;
        g     = GLY_BLANK;
        for (int d = 0; d < N_DIGITS; d++) begin
            if (r_bcd[4*d +: 4] != 4'd0) msnz = d;
            if (r_dp[d])                 hdp  = d;
        end
        top  = r_blz ? ((msnz > hdp) ? msnz : hdp) : N_DIGITS - 1;
        mpos = (top < N_DIGITS - 1) ? top + 1 : N_DIGITS - 1;
        w_fmt = '1;
        for (int d = 0; d < N_DIGITS; d++) begin
            g = (d > top) ? GLY_BLANK : f_glyph(r_bcd[4*d +: 4]);
            if (r_neg && d == mpos) g = GLY_DASH;
            if (w_ovf)              g = GLY_DASH;
            w_fmt[8*d +: 8] = {~r_dp[d], g};
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_next = S_SHIFT;
            S_SHIFT:  if (r_cnt == CW'(W_IN - 1)) w_next = S_FORMAT;
            S_FORMAT: w_next = S_OUT;
            S_OUT:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_cnt     <= '0;
            r_mag     <= '0;
            r_bcd     <= '0;
            r_lost    <= 1'b0;
            r_neg     <= 1'b0;
            r_dp      <= '0;
            r_blz     <= 1'b0;
            r_fmt     <= '1;
            r_fmt_ovf <= 1'b0;
            r_seg     <= '1;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_mag  <= w_mag_in;
                        r_neg  <= w_neg_in;
                        r_dp   <= i_DP;
                        r_blz  <= i_blank_lz;
                        r_bcd  <= '0;
                        r_lost <= 1'b0;
                        r_cnt  <= '0;
                    end
                end
                S_SHIFT: begin
                    r_bcd  <= {w_bcd_adj[BW-2:0], r_mag[W_IN-1]};
                    r_mag  <= r_mag << 1;
                    r_lost <= r_lost | w_bcd_adj[BW-1];
                    r_cnt  <= r_cnt + CW'(1);
                end
                S_FORMAT: begin
                    r_fmt     <= w_fmt;
                    r_fmt_ovf <= w_ovf;
                end
                S_OUT: begin
                    r_seg  <= r_fmt;
                    r_ovf  <= r_fmt_ovf;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (r_state != S_IDLE);
    assign o_done = r_done;
    assign o_ovf  = r_ovf;
    assign o_SEG  = r_seg;

endmodule
